// File: rtl/vslc_program_fetcher.sv
// Program RAM + cyclic scanner feeding the VSLC executor one byte per cycle.
// Optional scan pacing (WAIT state, scan_period input) under VSLC_FETCH_SCAN_TIMER_EN.
module vslc_program_fetcher #(
  parameter int         ADDR_W     = 5,
  parameter int         PROG_DEPTH = 32,
  parameter logic [7:0] END_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_overflow,
  input  logic [7:0]        ui_in,
  output logic [7:0]        instr,
  output logic              instr_ready,
  output logic [7:0]        ui_in_scan,
  output logic [7:0]        ui_in_prev,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              scan_done
`ifdef VSLC_FETCH_SCAN_TIMER_EN
  ,
  input  logic [15:0]       scan_period
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = PROG_DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t state_r, state_next_s;

  // pc is kept one bit wider internally so a full RAM can reach pc == prog_len.
  logic [ADDR_W:0] wptr_r, wptr_next_s;
  logic [ADDR_W:0] pc_cnt_r, pc_cnt_next_s;
  logic [ADDR_W:0] prog_len_r, prog_len_next_s;
  logic [7:0]      instr_r, instr_next_s;
  logic [7:0]      ui_in_scan_r, ui_in_scan_next_s;
  logic [7:0]      ui_in_prev_r, ui_in_prev_next_s;
  logic            instr_ready_r, instr_ready_next_s;
  logic            scan_done_r, scan_done_next_s;
  logic            ld_ready_r, ld_ready_next_s;
  logic            ld_overflow_r, ld_overflow_next_s;
  logic            param_next_r, param_next_next_s;
  logic            mem_we_s;
  logic [7:0]      mem_r [PROG_DEPTH];
  logic [7:0]      cur_byte_s;
  logic            eos_s;
  logic            wait_s;

  assign cur_byte_s = mem_r[pc_cnt_r[ADDR_W-1:0]];
  // A pending parameter byte is never taken as an end marker.
  assign eos_s = (pc_cnt_r == prog_len_r) ||
                 ((cur_byte_s == END_OPCODE) && !param_next_r);

`ifdef VSLC_FETCH_SCAN_TIMER_EN
  logic [15:0] timer_r, timer_next_s;
  logic [16:0] elapsed_s;

  // elapsed counts the cycle currently being closed, so a scan whose natural
  // length equals scan_period needs no WAIT cycles.
  assign elapsed_s = {1'b0, timer_r} + 17'd1;
  assign wait_s    = (scan_period != 16'd0) && (elapsed_s < {1'b0, scan_period});

  // Scan timer: restarts at every scan start, otherwise free-running.
  always_comb begin
    timer_next_s = timer_r + 16'd1;
    if (scan_done_next_s || ((state_r == ST_IDLE) && (state_next_s == ST_RUN))) begin
      timer_next_s = 16'd0;
    end else begin
      timer_next_s = timer_r + 16'd1;
    end
  end

  // Scan timer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r <= 16'd0;
    end else begin
      timer_r <= timer_next_s;
    end
  end
`else
  assign wait_s = 1'b0;
`endif

  // Next-state decode; ld_start always wins over run_en.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ld_start)    state_next_s = ST_LOAD;
        else if (run_en) state_next_s = ST_RUN;
        else             state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (ld_start)                  state_next_s = ST_LOAD;
        else if (ld_valid && ld_last)  state_next_s = ST_IDLE;
        else                           state_next_s = ST_LOAD;
      end
      ST_RUN: begin
        if (ld_start)                          state_next_s = ST_LOAD;
        else if (!run_en && !param_next_r)     state_next_s = ST_IDLE;
        else if (eos_s && wait_s)              state_next_s = ST_WAIT;
        else                                   state_next_s = ST_RUN;
      end
`ifdef VSLC_FETCH_SCAN_TIMER_EN
      ST_WAIT: begin
        if (ld_start)     state_next_s = ST_LOAD;
        else if (!run_en) state_next_s = ST_IDLE;
        else if (!wait_s) state_next_s = ST_RUN;
        else              state_next_s = ST_WAIT;
      end
`endif
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values for the registered outputs.
  always_comb begin
    wptr_next_s        = wptr_r;
    pc_cnt_next_s      = pc_cnt_r;
    prog_len_next_s    = prog_len_r;
    instr_next_s       = instr_r;
    instr_ready_next_s = 1'b0;
    ui_in_scan_next_s  = ui_in_scan_r;
    ui_in_prev_next_s  = ui_in_prev_r;
    scan_done_next_s   = 1'b0;
    ld_overflow_next_s = ld_overflow_r;
    param_next_next_s  = param_next_r;
    mem_we_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ld_start) begin
          wptr_next_s        = '0;
          ld_overflow_next_s = 1'b0;
          instr_next_s       = 8'h00;
        end else if (run_en) begin
          pc_cnt_next_s     = '0;
          ui_in_scan_next_s = ui_in;
          ui_in_prev_next_s = ui_in;
          param_next_next_s = 1'b0;
        end else begin
          instr_ready_next_s = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_start) begin
          wptr_next_s        = '0;
          ld_overflow_next_s = 1'b0;
        end else if (ld_valid) begin
          if (wptr_r < DEPTH_C) begin
            mem_we_s    = 1'b1;
            wptr_next_s = wptr_r + ONE_C;
            if (ld_last) prog_len_next_s = wptr_r + ONE_C;
            else         prog_len_next_s = prog_len_r;
          end else begin
            ld_overflow_next_s = 1'b1;
            if (ld_last) prog_len_next_s = DEPTH_C;
            else         prog_len_next_s = prog_len_r;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (ld_start) begin
          wptr_next_s        = '0;
          ld_overflow_next_s = 1'b0;
          instr_next_s       = 8'h00;
        end else if (!run_en && !param_next_r) begin
          instr_next_s = 8'h00;
        end else if (eos_s) begin
          instr_next_s      = 8'h00;
          pc_cnt_next_s     = '0;
          param_next_next_s = 1'b0;
          if (wait_s) begin
            scan_done_next_s = 1'b0;
          end else begin
            scan_done_next_s  = 1'b1;
            ui_in_prev_next_s = ui_in_scan_r;
            ui_in_scan_next_s = ui_in;
          end
        end else begin
          instr_next_s       = cur_byte_s;
          instr_ready_next_s = 1'b1;
          pc_cnt_next_s      = pc_cnt_r + ONE_C;
          // A parameter byte never arms another parameter.
          if (param_next_r) param_next_next_s = 1'b0;
          else              param_next_next_s = (cur_byte_s[7:4] == 4'hE);
        end
      end
`ifdef VSLC_FETCH_SCAN_TIMER_EN
      ST_WAIT: begin
        if (ld_start) begin
          wptr_next_s        = '0;
          ld_overflow_next_s = 1'b0;
        end else if (run_en && !wait_s) begin
          scan_done_next_s  = 1'b1;
          ui_in_prev_next_s = ui_in_scan_r;
          ui_in_scan_next_s = ui_in;
        end else begin
          scan_done_next_s = 1'b0;
        end
      end
`endif
      default: begin
        instr_next_s = 8'h00;
      end
    endcase
    ld_ready_next_s = (state_next_s == ST_LOAD) && (wptr_next_s < DEPTH_C);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      wptr_r        <= '0;
      pc_cnt_r      <= '0;
      prog_len_r    <= '0;
      instr_r       <= 8'h00;
      instr_ready_r <= 1'b0;
      ui_in_scan_r  <= 8'h00;
      ui_in_prev_r  <= 8'h00;
      scan_done_r   <= 1'b0;
      ld_ready_r    <= 1'b0;
      ld_overflow_r <= 1'b0;
      param_next_r  <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wptr_r        <= wptr_next_s;
      pc_cnt_r      <= pc_cnt_next_s;
      prog_len_r    <= prog_len_next_s;
      instr_r       <= instr_next_s;
      instr_ready_r <= instr_ready_next_s;
      ui_in_scan_r  <= ui_in_scan_next_s;
      ui_in_prev_r  <= ui_in_prev_next_s;
      scan_done_r   <= scan_done_next_s;
      ld_ready_r    <= ld_ready_next_s;
      ld_overflow_r <= ld_overflow_next_s;
      param_next_r  <= param_next_next_s;
    end
  end

  // Program RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wptr_r[ADDR_W-1:0]] <= ld_data;
    end
  end

  assign ld_ready    = ld_ready_r;
  assign ld_overflow = ld_overflow_r;
  assign instr       = instr_r;
  assign instr_ready = instr_ready_r;
  assign ui_in_scan  = ui_in_scan_r;
  assign ui_in_prev  = ui_in_prev_r;
  assign pc          = pc_cnt_r[ADDR_W-1:0];
  assign prog_len    = prog_len_r;
  assign scan_done   = scan_done_r;

endmodule

// File: tb/tb_vslc_program_fetcher.sv
// Self-checking bench for vslc_program_fetcher: scenario tasks with an instr scoreboard.
module tb_vslc_program_fetcher;

  logic       clk = 1'b0;
  logic       rst_n, run_en, ld_start, ld_valid, ld_last;
  logic [7:0] ld_data, ui_in;
  logic       ld_ready, ld_overflow, instr_ready, scan_done;
  logic [7:0] instr, ui_in_scan, ui_in_prev;
  logic [4:0] pc;
  logic [5:0] prog_len;
`ifdef VSLC_FETCH_SCAN_TIMER_EN
  logic [15:0] scan_period;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prog_buf [40];
  logic [7:0] exp_b;

  vslc_program_fetcher dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_overflow(ld_overflow), .ui_in(ui_in),
    .instr(instr), .instr_ready(instr_ready), .ui_in_scan(ui_in_scan),
    .ui_in_prev(ui_in_prev), .pc(pc), .prog_len(prog_len), .scan_done(scan_done)
`ifdef VSLC_FETCH_SCAN_TIMER_EN
    , .scan_period(scan_period)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog_buf[i];
      ld_last  = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (instr !== 8'h00) begin n_fail++; $display("FAIL rst_instr: got %0h expected 0", instr); end
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_instr_ready: got %0b expected 0", instr_ready); end
    n_checks++; if (pc !== 5'd0) begin n_fail++; $display("FAIL rst_pc: got %0d expected 0", pc); end
    n_checks++; if (prog_len !== 6'd0) begin n_fail++; $display("FAIL rst_prog_len: got %0d expected 0", prog_len); end
    n_checks++; if (ui_in_scan !== 8'h00 || ui_in_prev !== 8'h00) begin n_fail++; $display("FAIL rst_snap: got %0h/%0h expected 0/0", ui_in_scan, ui_in_prev); end
    n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_scan_done: got %0b expected 0", scan_done); end
    n_checks++; if (ld_ready !== 1'b0 || ld_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ld: got rdy=%0b ovf=%0b expected 0/0", ld_ready, ld_overflow); end
    rst_n = 1'b1;
    tick();
  endtask

  // prog_len==0 right after reset: every RUN cycle ends a scan.
  task automatic test_empty_prog();
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (scan_done !== 1'b1 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL empty_k%0d: got sd=%0b rdy=%0b expected sd=1 rdy=0", k, scan_done, instr_ready); end
    end
    run_en = 1'b0;
    tick();
    n_checks++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL empty_stop: got sd=%0b expected 0", scan_done); end
    tick();
  endtask

  task automatic test_basic_scan();
    prog_buf[0] = 8'h00; prog_buf[1] = 8'h10; prog_buf[2] = 8'hFF;
    load_prog(3);
    n_checks++; if (prog_len !== 6'd3) begin n_fail++; $display("FAIL basic_prog_len: got %0d expected 3", prog_len); end
    n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ld_ready: got %0b expected 0", ld_ready); end
    ui_in  = 8'h01;
    run_en = 1'b1;
    tick();
    n_checks++; if (ui_in_scan !== 8'h01 || ui_in_prev !== 8'h01) begin n_fail++; $display("FAIL basic_snap: got %0h/%0h expected 01/01", ui_in_scan, ui_in_prev); end
    n_checks++; if (instr_ready !== 1'b0 || pc !== 5'd0) begin n_fail++; $display("FAIL basic_start: got rdy=%0b pc=%0d expected 0/0", instr_ready, pc); end
    exp_q.delete();
    repeat (3) begin exp_q.push_back(8'h00); exp_q.push_back(8'h10); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++; if (instr_ready !== (k % 3 != 0)) begin n_fail++; $display("FAIL basic_rdy_k%0d: got %0b expected %0b", k, instr_ready, (k % 3 != 0)); end
      n_checks++; if (scan_done !== (k % 3 == 0)) begin n_fail++; $display("FAIL basic_sd_k%0d: got %0b expected %0b", k, scan_done, (k % 3 == 0)); end
      if (instr_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_instr_k%0d: got %0h expected none", k, instr); end
        else begin exp_b = exp_q.pop_front(); if (instr !== exp_b) begin n_fail++; $display("FAIL basic_instr_k%0d: got %0h expected %0h", k, instr, exp_b); end end
      end else begin
        n_checks++; if (instr !== 8'h00) begin n_fail++; $display("FAIL basic_eos_instr_k%0d: got %0h expected 0", k, instr); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: got %0d left expected 0", exp_q.size()); end
    run_en = 1'b0;
    tick();
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL basic_halt: got %0b expected 0", instr_ready); end
    tick();
  endtask

  task automatic test_snapshot();
    ui_in  = 8'h01;
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) ui_in = 8'h03;
      if (k == 2) begin
        n_checks++; if (ui_in_scan !== 8'h01) begin n_fail++; $display("FAIL snap_mid: got %0h expected 01", ui_in_scan); end
      end
      if (k == 3) begin
        n_checks++; if (ui_in_scan !== 8'h03 || ui_in_prev !== 8'h01) begin n_fail++; $display("FAIL snap_wrap: got %0h/%0h expected 03/01", ui_in_scan, ui_in_prev); end
      end
      if (k == 6) begin
        n_checks++; if (ui_in_prev !== 8'h03) begin n_fail++; $display("FAIL snap_prev2: got %0h expected 03", ui_in_prev); end
      end
    end
    run_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_sparam();
    prog_buf[0] = 8'hE1; prog_buf[1] = 8'hFF; prog_buf[2] = 8'h02;
    load_prog(3);
    n_checks++; if (prog_len !== 6'd3) begin n_fail++; $display("FAIL sparam_prog_len: got %0d expected 3", prog_len); end
    exp_q.delete();
    repeat (2) begin exp_q.push_back(8'hE1); exp_q.push_back(8'hFF); exp_q.push_back(8'h02); end
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++; if (instr_ready !== (k % 4 != 0) || scan_done !== (k % 4 == 0)) begin n_fail++; $display("FAIL sparam_k%0d: got rdy=%0b sd=%0b expected rdy=%0b sd=%0b", k, instr_ready, scan_done, (k % 4 != 0), (k % 4 == 0)); end
      if (instr_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL sparam_instr_k%0d: got %0h expected none", k, instr); end
        else begin exp_b = exp_q.pop_front(); if (instr !== exp_b) begin n_fail++; $display("FAIL sparam_instr_k%0d: got %0h expected %0h", k, instr, exp_b); end end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sparam_drain: got %0d left expected 0", exp_q.size()); end
    run_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_run_drop();
    prog_buf[0] = 8'h01; prog_buf[1] = 8'hE5; prog_buf[2] = 8'h22; prog_buf[3] = 8'h33;
    load_prog(4);
    exp_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'hE5); exp_q.push_back(8'h22);
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) begin
        n_checks++;
        if (instr_ready !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL drop_fwd_k%0d: got rdy=%0b expected 1", k, instr_ready); end
        else begin exp_b = exp_q.pop_front(); if (instr !== exp_b) begin n_fail++; $display("FAIL drop_instr_k%0d: got %0h expected %0h", k, instr, exp_b); end end
      end else begin
        n_checks++; if (instr_ready !== 1'b0 || pc !== 5'd3) begin n_fail++; $display("FAIL drop_idle_k%0d: got rdy=%0b pc=%0d expected 0/3", k, instr_ready, pc); end
      end
      if (k == 2) run_en = 1'b0;
    end
    run_en = 1'b1;
    tick();
    n_checks++; if (pc !== 5'd0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL drop_restart: got pc=%0d rdy=%0b expected 0/0", pc, instr_ready); end
    exp_q.push_back(8'h01);
    tick();
    n_checks++;
    if (instr_ready !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL drop_first: got rdy=%0b expected 1", instr_ready); end
    else begin exp_b = exp_q.pop_front(); if (instr !== exp_b || pc !== 5'd1) begin n_fail++; $display("FAIL drop_first: got %0h pc=%0d expected %0h pc=1", instr, pc, exp_b); end end
    run_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_ld_start_priority();
    prog_buf[0] = 8'h00; prog_buf[1] = 8'h10; prog_buf[2] = 8'hFF;
    load_prog(3);
    run_en = 1'b1;
    repeat (2) tick();
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL prio_running: got %0b expected 1", instr_ready); end
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_checks++; if (instr_ready !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ld_start: got rdy=%0b ld_rdy=%0b expected 0/1", instr_ready, ld_ready); end
    tick();
    n_checks++; if (instr_ready !== 1'b0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL prio_load_hold: got rdy=%0b ld_rdy=%0b expected 0/1", instr_ready, ld_ready); end
    run_en = 1'b0;
  endtask

  task automatic test_overflow();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_checks++; if (ld_ready !== 1'b1 || ld_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_start: got rdy=%0b ovf=%0b expected 1/0", ld_ready, ld_overflow); end
    for (int i = 0; i <= 32; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      ld_last  = (i == 32);
      tick();
      if (i == 30) begin
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy31: got %0b expected 1", ld_ready); end
      end
      if (i == 31) begin
        n_checks++; if (ld_ready !== 1'b0 || ld_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got rdy=%0b ovf=%0b expected 0/0", ld_ready, ld_overflow); end
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    n_checks++; if (ld_overflow !== 1'b1 || prog_len !== 6'd32 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_end: got ovf=%0b len=%0d rdy=%0b expected 1/32/0", ld_overflow, prog_len, ld_ready); end
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 33; k++) begin
      tick();
      n_checks++; if (instr_ready !== (k <= 32) || scan_done !== (k == 33)) begin n_fail++; $display("FAIL full_k%0d: got rdy=%0b sd=%0b expected rdy=%0b sd=%0b", k, instr_ready, scan_done, (k <= 32), (k == 33)); end
      if (instr_ready === 1'b1 && exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        n_checks++; if (instr !== exp_b) begin n_fail++; $display("FAIL full_instr_k%0d: got %0h expected %0h", k, instr, exp_b); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: got %0d left expected 0", exp_q.size()); end
    run_en = 1'b0;
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_checks++; if (ld_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b expected 0", ld_overflow); end
  endtask

`ifdef VSLC_FETCH_SCAN_TIMER_EN
  task automatic test_scan_timer();
    prog_buf[0] = 8'h00; prog_buf[1] = 8'h10; prog_buf[2] = 8'hFF;
    load_prog(3);
    scan_period = 16'd10;
    exp_q.delete();
    repeat (3) begin exp_q.push_back(8'h00); exp_q.push_back(8'h10); end
    run_en = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++; if (instr_ready !== ((k % 10 == 1) || (k % 10 == 2)) || scan_done !== (k % 10 == 0)) begin n_fail++; $display("FAIL timer_k%0d: got rdy=%0b sd=%0b", k, instr_ready, scan_done); end
      if (instr_ready === 1'b1 && exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        n_checks++; if (instr !== exp_b) begin n_fail++; $display("FAIL timer_instr_k%0d: got %0h expected %0h", k, instr, exp_b); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL timer_drain: got %0d left expected 0", exp_q.size()); end
    run_en      = 1'b0;
    scan_period = 16'd0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; run_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    ld_last = 1'b0; ld_data = 8'h00; ui_in = 8'h00;
`ifdef VSLC_FETCH_SCAN_TIMER_EN
    scan_period = 16'd0;
`endif
    test_reset();
    test_empty_prog();
    test_basic_scan();
    test_snapshot();
    test_sparam();
    test_run_drop();
    test_ld_start_priority();
    test_overflow();
`ifdef VSLC_FETCH_SCAN_TIMER_EN
    test_scan_timer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
